// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_pkg;

  // Byte-level protocol states of the target.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // The target owns the transfer from the address ACK up to the end of a read ACK slot.
  function automatic logic state_is_busy(input i2c_state_e s);
    return (s == ST_ADDR_ACK) || (s == ST_WRITE) || (s == ST_WRITE_ACK) ||
           (s == ST_READ) || (s == ST_READ_ACK);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer plus edge detector for one asynchronous I2C pad line.
// Optional 3-sample majority filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              sync_out;
  logic              clean;
  logic              prev_q;

  // Metastability chain; resets to 1 because an idle bus is pulled high.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], line_i};
  end

  assign sync_out = sync_q[STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  // Two older samples kept for the majority vote.
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], sync_out};
  end

  // A single-cycle pulse only ever occupies one of the three votes.
  assign clean = (sync_out & hist_q[0]) | (sync_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign clean = sync_out;
`endif

  // Previous clean sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= clean;
  end

  assign level_o = clean;
  assign rise_o  = clean & ~prev_q;
  assign fall_o  = ~clean & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target: START/STOP detection, 7-bit address match,
// write-byte reception and read-byte transmission.
// Optional glitch filter on both lines: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       rw_q, rw_d;
  logic       ack_got_q, ack_got_d;

  logic       start_cond, stop_cond;
  logic [7:0] byte_in;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign byte_in    = {shift_q[6:0], sda_lvl};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rw_q       <= I2C_RW_WRITE;
      ack_got_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rw_q       <= rw_d;
      ack_got_q  <= ack_got_d;
    end
  end

  // Next-state and output logic; bus conditions take priority over bit traffic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    rw_d       = rw_q;
    ack_got_d  = ack_got_q;

    if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      start_d   = 1'b1;
      ack_got_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      stop_d    = 1'b1;
      ack_got_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = sda_lvl;
              state_d = (shift_q[6:0] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
        end

        // sda_oe doubles as the phase flag: first fall drives ACK, second ends the slot.
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
              if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) tx_req_d = 1'b1;
            end else begin
              bit_cnt_d = 3'd0;
              if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                shift_d  = tx_data;
                sda_oe_d = ~tx_data[7];
                state_d  = ST_READ;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WRITE;
              end
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = ST_WRITE_ACK;
            end
          end
        end

        ST_READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_READ_ACK;
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end

        // Release after the last data bit, sample the controller's ACK, then reload.
        ST_READ_ACK: begin
          if (scl_fall) begin
            if (ack_got_q) begin
              ack_got_d = 1'b0;
              bit_cnt_d = 3'd0;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              state_d   = ST_READ;
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              tx_req_d  = 1'b1;
              ack_got_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign busy      = state_is_busy(state_q);

endmodule
